// File: rtl/vx_tile_ctl_unit_pkg.sv
// Shared types for the tile-group controller.
//   tile_op_t   : request opcode (SET/ADD/RELEASE/QUERY)
//   tile_sts_t  : response status (OK/CONFLICT/INVALID)
//   tile_fsm_t  : controller sequencing states
//   tile_ent_t  : layout of one table entry at the default widths
//   up_clog2    : clog2 clamped to a minimum of 1 bit
package vx_tile_ctl_unit_pkg;

    localparam int DEF_NUM_WARPS  = 8;
    localparam int DEF_TCNT_WIDTH = 8;

    typedef enum logic [1:0] {
        TILE_OP_SET     = 2'd0,
        TILE_OP_ADD     = 2'd1,
        TILE_OP_RELEASE = 2'd2,
        TILE_OP_QUERY   = 2'd3
    } tile_op_t;

    typedef enum logic [1:0] {
        TILE_STS_OK       = 2'd0,
        TILE_STS_CONFLICT = 2'd1,
        TILE_STS_INVALID  = 2'd2
    } tile_sts_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_COMMIT = 2'd2,
        ST_RSP    = 2'd3
    } tile_fsm_t;

    typedef struct packed {
        logic                      valid;
        logic [DEF_NUM_WARPS-1:0]  wmask;
        logic [DEF_TCNT_WIDTH-1:0] tcount;
    } tile_ent_t;

    function automatic int up_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_tile_ctl_unit_lookup.sv
// Per-warp tile lookup: for every warp, finds the lowest-index valid tile whose
// warp mask contains it.
//   tile_valid   in  : per-entry valid bits
//   tile_wmask   in  : per-entry warp masks, entry t at [t*NUM_WARPS +: NUM_WARPS]
//   warp_in_tile out : warp belongs to at least one valid tile
//   warp_tile_id out : lowest matching tile id per warp (0 if none)
module vx_tile_lookup
    import vx_tile_ctl_unit_pkg::*;
#(
    parameter int NUM_WARPS = 8,
    parameter int NUM_TILES = 4,
    localparam int TILE_BITS = up_clog2(NUM_TILES)
) (
    input  logic [NUM_TILES-1:0]           tile_valid,
    input  logic [NUM_TILES*NUM_WARPS-1:0] tile_wmask,
    output logic [NUM_WARPS-1:0]           warp_in_tile,
    output logic [NUM_WARPS*TILE_BITS-1:0] warp_tile_id
);

    // Walk tiles from high to low so the last (lowest-index) match wins.
    always_comb begin
        warp_in_tile = '0;
        warp_tile_id = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            for (int t = NUM_TILES - 1; t >= 0; t--) begin
                if (tile_valid[t] && tile_wmask[t*NUM_WARPS + w]) begin
                    warp_in_tile[w] = 1'b1;
                    warp_tile_id[w*TILE_BITS +: TILE_BITS] = TILE_BITS'(t);
                end
            end
        end
    end

endmodule

// File: rtl/vx_tile_ctl_unit.sv
// Tile-group controller. Serialises SET/ADD/RELEASE/QUERY requests from the SFU
// against a NUM_TILES-entry table and publishes the table plus a per-warp map.
//   req_*   : request channel; req_ready is high only while idle
//   rsp_*   : response channel; held stable until rsp_ready
//   tile_*  : table contents (valid, flattened warp masks, flattened thread counts)
//   warp_*  : per-warp membership and lowest owning tile id
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; the sender holds its payload stable while valid is high and ready is low.
module vx_tile_ctl_unit
    import vx_tile_ctl_unit_pkg::*;
#(
    parameter int NUM_WARPS     = 8,
    parameter int NUM_THREADS   = 8,
    parameter int NUM_TILES     = 4,
    parameter int TCNT_WIDTH    = 8,
    parameter int ALLOW_OVERLAP = 0,
    localparam int NW_WIDTH  = up_clog2(NUM_WARPS),
    localparam int TILE_BITS = up_clog2(NUM_TILES)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [1:0]                      req_op,
    input  logic [NW_WIDTH-1:0]             req_wid,
    input  logic [TILE_BITS-1:0]            req_tile_id,
    input  logic [NUM_WARPS-1:0]            req_wmask,
    input  logic [TCNT_WIDTH-1:0]           req_tcount,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [NW_WIDTH-1:0]             rsp_wid,
    output logic [TILE_BITS-1:0]            rsp_tile_id,
    output logic [1:0]                      rsp_status,
    output logic [NUM_TILES-1:0]            tile_valid,
    output logic [NUM_TILES*NUM_WARPS-1:0]  tile_wmask,
    output logic [NUM_TILES*TCNT_WIDTH-1:0] tile_tcount,
    output logic [NUM_WARPS-1:0]            warp_in_tile,
    output logic [NUM_WARPS*TILE_BITS-1:0]  warp_tile_id
);

    // Thread-count comparisons run at a width that holds both operands.
    localparam int TC_NEED  = $clog2(NUM_THREADS + 1);
    localparam int TC_CMP_W = (TCNT_WIDTH > TC_NEED) ? TCNT_WIDTH : TC_NEED;

    tile_fsm_t                                state;
    tile_op_t                                 op_q;
    logic [NW_WIDTH-1:0]                      wid_q;
    logic [TILE_BITS-1:0]                     tile_q;
    logic [NUM_WARPS-1:0]                     wmask_q;
    logic [TCNT_WIDTH-1:0]                    tcount_q;
    tile_sts_t                                sts_q;

    logic [NUM_TILES-1:0]                     tbl_valid;
    logic [NUM_TILES-1:0][NUM_WARPS-1:0]      tbl_wmask;
    logic [NUM_TILES-1:0][TCNT_WIDTH-1:0]     tbl_tcount;

    logic [NUM_WARPS-1:0]                     lk_in;
    logic [NUM_WARPS-1:0][TILE_BITS-1:0]      lk_id;
    logic [NUM_WARPS*TILE_BITS-1:0]           lk_id_flat;

    logic                                     tile_ok;
    logic                                     tgt_valid;
    logic [NUM_WARPS-1:0]                     other_mask;
    logic                                     conflict;
    logic [TC_CMP_W-1:0]                      tc_ext;
    logic                                     tc_bad;
    tile_sts_t                                chk_sts;
    logic [TILE_BITS-1:0]                     chk_tile;

    vx_tile_lookup #(
        .NUM_WARPS (NUM_WARPS),
        .NUM_TILES (NUM_TILES)
    ) u_lookup (
        .tile_valid   (tbl_valid),
        .tile_wmask   (tbl_wmask),
        .warp_in_tile (lk_in),
        .warp_tile_id (lk_id_flat)
    );

    assign lk_id        = lk_id_flat;
    assign tile_valid   = tbl_valid;
    assign tile_wmask   = tbl_wmask;
    assign tile_tcount  = tbl_tcount;
    assign warp_in_tile = lk_in;
    assign warp_tile_id = lk_id_flat;
    assign rsp_status   = sts_q;

    // Target decode; looping over real entries keeps an out-of-range id
    // (non-power-of-two NUM_TILES) from ever indexing the table.
    always_comb begin
        tile_ok    = 1'b0;
        tgt_valid  = 1'b0;
        other_mask = '0;
        for (int i = 0; i < NUM_TILES; i++) begin
            if (TILE_BITS'(i) == tile_q) begin
                tile_ok   = 1'b1;
                tgt_valid = tbl_valid[i];
            end else if (tbl_valid[i]) begin
                other_mask = other_mask | tbl_wmask[i];
            end
        end
    end

    assign conflict = (ALLOW_OVERLAP == 0) && ((wmask_q & other_mask) != '0);
    assign tc_ext   = TC_CMP_W'(tcount_q);
    assign tc_bad   = (tc_ext == '0) || (tc_ext > TC_CMP_W'(NUM_THREADS));

    always_comb begin
        chk_sts  = TILE_STS_OK;
        chk_tile = tile_q;
        case (op_q)
            TILE_OP_SET: begin
                if (!tile_ok || wmask_q == '0 || tc_bad) chk_sts = TILE_STS_INVALID;
                else if (conflict)                       chk_sts = TILE_STS_CONFLICT;
            end
            TILE_OP_ADD: begin
                if (!tgt_valid || wmask_q == '0) chk_sts = TILE_STS_INVALID;
                else if (conflict)               chk_sts = TILE_STS_CONFLICT;
            end
            TILE_OP_RELEASE: begin
                if (!tgt_valid) chk_sts = TILE_STS_INVALID;
            end
            TILE_OP_QUERY: begin
                if (lk_in[wid_q]) begin
                    chk_tile = lk_id[wid_q];
                end else begin
                    chk_sts  = TILE_STS_INVALID;
                    chk_tile = '0;
                end
            end
            default: chk_sts = TILE_STS_INVALID;
        endcase
    end

    // Only COMMIT writes the table, so a reset in any other state cannot
    // leave a half-applied request behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_wid     <= '0;
            rsp_tile_id <= '0;
            sts_q       <= TILE_STS_OK;
            op_q        <= TILE_OP_SET;
            wid_q       <= '0;
            tile_q      <= '0;
            wmask_q     <= '0;
            tcount_q    <= '0;
            tbl_valid   <= '0;
            tbl_wmask   <= '0;
            tbl_tcount  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q      <= tile_op_t'(req_op);
                        wid_q     <= req_wid;
                        tile_q    <= req_tile_id;
                        wmask_q   <= req_wmask;
                        tcount_q  <= req_tcount;
                        req_ready <= 1'b0;
                        state     <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    sts_q       <= chk_sts;
                    rsp_tile_id <= chk_tile;
                    rsp_wid     <= wid_q;
                    state       <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    if (sts_q == TILE_STS_OK) begin
                        for (int i = 0; i < NUM_TILES; i++) begin
                            if (TILE_BITS'(i) == tile_q) begin
                                case (op_q)
                                    TILE_OP_SET: begin
                                        tbl_valid[i]  <= 1'b1;
                                        tbl_wmask[i]  <= wmask_q;
                                        tbl_tcount[i] <= tcount_q;
                                    end
                                    TILE_OP_ADD: tbl_wmask[i] <= tbl_wmask[i] | wmask_q;
                                    TILE_OP_RELEASE: begin
                                        tbl_valid[i]  <= 1'b0;
                                        tbl_wmask[i]  <= '0;
                                        tbl_tcount[i] <= '0;
                                    end
                                    default: ;
                                endcase
                            end
                        end
                    end
                    rsp_valid <= 1'b1;
                    state     <= ST_RSP;
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
